// File: rtl/router_pkg.sv
// Shared router definitions: scheduler FSM encodings,
// active-port codes and the default field width.
package router_pkg;

    localparam int DEF_WIDTH = 8;

    typedef logic [1:0] port_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam port_t PORT_NONE = 2'b00;
    localparam port_t PORT_1    = 2'b01;
    localparam port_t PORT_2    = 2'b10;

endpackage

// File: rtl/spi_tx_scheduler_if.sv
// Port-side and SPI-side signals of the SPI transmit scheduler.
// slave is the scheduler view, master the requester/SPI view.
interface spi_tx_scheduler_if #(
    parameter int WIDTH = router_pkg::DEF_WIDTH
);
    import router_pkg::*;

    logic             req1;
    logic [WIDTH-1:0] des1;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] check1;
    logic             req2;
    logic [WIDTH-1:0] des2;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] check2;
    logic             spiBusy;
    logic             spiDone;
    logic             spiStart;
    logic [WIDTH-1:0] spiByte;
    logic             ack1;
    logic             ack2;
    logic             timeoutErr;
    port_t            activePort;

    modport slave (
        input  req1, des1, data1, check1,
        input  req2, des2, data2, check2,
        input  spiBusy, spiDone,
        output spiStart, spiByte, ack1, ack2,
        output timeoutErr, activePort
    );

    modport master (
        output req1, des1, data1, check1,
        output req2, des2, data2, check2,
        output spiBusy, spiDone,
        input  spiStart, spiByte, ack1, ack2,
        input  timeoutErr, activePort
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer only moves
// when a transfer finishes (ack or abort).
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       last,
    output logic [1:0] grant
);

    logic favour2;

    // last is high when port 2 was the one just served
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            favour2 <= 1'b0;
        end else if (update) begin
            favour2 <= !last;
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = favour2 ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Shares one SPI transmitter between two output ports, sending
// each granted packet as des, data, check with a per-byte timeout.
module spi_tx_scheduler
    import router_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    spi_tx_scheduler_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT);
    // last WAIT cycle is the one whose increment reaches TIMEOUT-1
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    logic [2:0]       state;
    port_t            port;
    logic [1:0]       idx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] check_q;
    logic [WIDTH-1:0] byte_q;
    logic [1:0]       grant;
    logic             done_xfer;

    assign done_xfer = (state == S_ACK) || (state == S_ERR);

    rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    ({bus.req2, bus.req1}),
        .update (done_xfer),
        .last   (port[1]),
        .grant  (grant)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            port    <= PORT_NONE;
            idx     <= 2'd0;
            cnt     <= '0;
            data_q  <= '0;
            check_q <= '0;
            byte_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant == PORT_1) begin
                        port    <= PORT_1;
                        idx     <= 2'd0;
                        byte_q  <= bus.des1;
                        data_q  <= bus.data1;
                        check_q <= bus.check1;
                        state   <= S_LOAD;
                    end else if (grant == PORT_2) begin
                        port    <= PORT_2;
                        idx     <= 2'd0;
                        byte_q  <= bus.des2;
                        data_q  <= bus.data2;
                        check_q <= bus.check2;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!bus.spiBusy) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (bus.spiDone) begin
                        if (idx == 2'd2) begin
                            state <= S_ACK;
                        end else begin
                            idx    <= idx + 2'd1;
                            byte_q <= (idx == 2'd0) ? data_q : check_q;
                            state  <= S_LOAD;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state <= S_ERR;
                    end
                end
                S_ACK, S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.spiStart   = (state == S_LOAD) && !bus.spiBusy;
    assign bus.spiByte    = byte_q;
    assign bus.ack1       = (state == S_ACK) && port[0];
    assign bus.ack2       = (state == S_ACK) && port[1];
    assign bus.timeoutErr = (state == S_ERR);
    assign bus.activePort = (state == S_IDLE) ? PORT_NONE : port;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Bench for spi_tx_scheduler: packet table with a byte/ack
// scoreboard, plus busy, stray-done, timeout and reset sequences.
module tb_spi_tx_scheduler;

    typedef struct {
        logic       r1;
        logic       r2;
        logic [7:0] d1, a1, c1;
        logic [7:0] d2, a2, c2;
        logic [1:0] first;
        int         dly;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic m_done = 1'b0;
    logic s_done = 1'b0;
    int   done_dly = 8;
    int   dcnt = 0;
    int   done_cyc = -100;
    logic [7:0] start_byte = 8'h00;

    logic [7:0] byte_q[$];
    logic [1:0] ack_q[$];

    spi_tx_scheduler_if #(.WIDTH(8)) b ();
    spi_tx_scheduler_if #(.WIDTH(8)) b8 ();

    spi_tx_scheduler #(.WIDTH(8), .TIMEOUT(64)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (b.slave)
    );

    spi_tx_scheduler #(.WIDTH(8), .TIMEOUT(8)) u_dut8 (
        .clock (clk),
        .reset (rst),
        .bus   (b8.slave)
    );

    assign b.spiDone   = m_done | s_done;
    assign b8.des1     = b.des1;
    assign b8.data1    = b.data1;
    assign b8.check1   = b.check1;
    assign b8.des2     = b.des2;
    assign b8.data2    = b.data2;
    assign b8.check2   = b.check2;
    assign b8.spiBusy  = 1'b0;
    assign b8.spiDone  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SPI shift engine model: done pulse done_dly cycles after start
    always @(negedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            dcnt = 0;
        end else begin
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    m_done = 1'b1;
                    done_cyc = cyc;
                    chk("byte_stable", b.spiByte, start_byte);
                end
            end
            if (b.spiStart) begin
                dcnt = done_dly;
                start_byte = b.spiByte;
            end
        end
    end

    // scoreboard: every start and ack must match the next expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (b.spiStart) begin
                chk("sb_start_expected", byte_q.size() != 0, 1);
                if (byte_q.size() != 0)
                    chk("sb_spiByte", b.spiByte, byte_q.pop_front());
            end
            if (b.ack1 || b.ack2) begin
                chk("sb_ack_expected", ack_q.size() != 0, 1);
                if (ack_q.size() != 0)
                    chk("sb_ack_port", {b.ack2, b.ack1}, ack_q.pop_front());
                chk("ack_after_done", cyc, done_cyc + 1);
            end
        end
    end

    task automatic push_pkt(input vec_t v, input logic [1:0] p);
        if (p == 2'b01) begin
            byte_q.push_back(v.d1);
            byte_q.push_back(v.a1);
            byte_q.push_back(v.c1);
        end else begin
            byte_q.push_back(v.d2);
            byte_q.push_back(v.a2);
            byte_q.push_back(v.c2);
        end
        ack_q.push_back(p);
    endtask

    task automatic load_vec(input vec_t v);
        done_dly = v.dly;
        push_pkt(v, v.first);
        if (v.r1 && v.r2)
            push_pkt(v, (v.first == 2'b01) ? 2'b10 : 2'b01);
        b.des1 = v.d1;
        b.data1 = v.a1;
        b.check1 = v.c1;
        b.des2 = v.d2;
        b.data2 = v.a2;
        b.check2 = v.c2;
        b.req1 = v.r1;
        b.req2 = v.r2;
    endtask

    task automatic wait_acks(input string nm, output int cack);
        cack = -1;
        for (int i = 0; i < 400 && (b.req1 || b.req2); i++) begin
            step();
            if ((b.ack1 || b.ack2) && cack < 0) cack = cyc;
            if (b.ack1) b.req1 = 1'b0;
            if (b.ack2) b.req2 = 1'b0;
        end
        chk({nm, "_reqs_done"}, {b.req1, b.req2}, 2'b00);
        step();
        chk({nm, "_idle"}, b.activePort, 2'b00);
        chk({nm, "_sb_empty"}, byte_q.size() + ack_q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int c0;
        int cack;
        c0 = cyc;
        load_vec(v);
        wait_acks(nm, cack);
        chk({nm, "_latency"}, cack - c0, 1 + 3 * (v.dly + 1));
    endtask

    vec_t vecs[6];
    vec_t sv;
    int   t0, t1, nack, ns, cack;

    initial begin
        b.req1 = 0; b.req2 = 0; b.spiBusy = 0;
        b.des1 = 0; b.data1 = 0; b.check1 = 0;
        b.des2 = 0; b.data2 = 0; b.check2 = 0;
        b8.req1 = 0; b8.req2 = 0;
        #2 rst = 1'b1;
        repeat (3) step();
        chk("rst_spiStart", b.spiStart, 0);
        chk("rst_spiByte", b.spiByte, 0);
        chk("rst_ack1", b.ack1, 0);
        chk("rst_ack2", b.ack2, 0);
        chk("rst_timeoutErr", b.timeoutErr, 0);
        chk("rst_activePort", b.activePort, 0);
        rst = 1'b0;
        step();

        vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'h99,
                    8'h00, 8'h00, 8'h00, 2'b01, 8};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00,
                    8'h11, 8'h22, 8'h33, 2'b10, 1};
        vecs[2] = '{1'b1, 1'b1, 8'h01, 8'h02, 8'h03,
                    8'hF0, 8'hE0, 8'hD0, 2'b01, 2};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'h00,
                    8'h12, 8'h34, 8'h56, 2'b01, 1};
        vecs[4] = '{1'b1, 1'b1, 8'h5A, 8'h5B, 8'h5C,
                    8'hC1, 8'hC2, 8'hC3, 2'b10, 4};
        vecs[5] = '{1'b1, 1'b1, 8'h81, 8'h42, 8'h24,
                    8'h18, 8'hE7, 8'h7E, 2'b10, 1};
        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // spiBusy held in LOAD
        sv = '{1'b1, 1'b0, 8'hB1, 8'hB2, 8'hB3,
               8'h00, 8'h00, 8'h00, 2'b01, 2};
        b.spiBusy = 1'b1;
        load_vec(sv);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("busy_hold", {b.spiStart, b.activePort}, 3'b001);
        end
        b.spiBusy = 1'b0;
        #1;
        chk("busy_release_start", b.spiStart, 1);
        step();
        chk("busy_single_pulse", b.spiStart, 0);
        wait_acks("busy", cack);

        // stray spiDone in IDLE and in LOAD
        s_done = 1'b1;
        step();
        s_done = 1'b0;
        chk("stray_idle", {b.activePort, b.ack1, b.ack2}, 0);
        sv = '{1'b1, 1'b0, 8'h6E, 8'h5D, 8'h4C,
               8'h00, 8'h00, 8'h00, 2'b01, 3};
        b.spiBusy = 1'b1;
        load_vec(sv);
        step();
        s_done = 1'b1;
        step();
        s_done = 1'b0;
        chk("stray_load", {b.spiStart, b.activePort, b.spiByte},
            {1'b0, 2'b01, 8'h6E});
        b.spiBusy = 1'b0;
        wait_acks("stray", cack);

        // timeout on the TIMEOUT=8 instance
        b8.req1 = 1'b1;
        t0 = -1;
        for (int i = 0; i < 10 && t0 < 0; i++) begin
            step();
            if (b8.spiStart) t0 = cyc;
        end
        chk("to_start_seen", t0 >= 0, 1);
        t1 = -1;
        nack = 0;
        for (int i = 0; i < 30 && t1 < 0; i++) begin
            step();
            if (b8.ack1 || b8.ack2) nack++;
            if (b8.timeoutErr) t1 = cyc;
        end
        chk("to_delay", t1 - t0, 8);
        chk("to_no_ack", nack, 0);
        b8.req2 = 1'b1;
        step();
        chk("to_pulse_then_idle", {b8.timeoutErr, b8.activePort}, 0);
        step();
        chk("to_rr_moves", b8.activePort, 2'b10);
        t1 = -1;
        for (int i = 0; i < 30 && t1 < 0; i++) begin
            step();
            if (b8.timeoutErr) t1 = cyc;
        end
        chk("to_second_err", t1 >= 0, 1);
        b8.req1 = 1'b0;
        b8.req2 = 1'b0;
        step();
        step();
        chk("to_back_idle", b8.activePort, 0);

        // reset during the 2nd byte of a port-2 packet
        sv = '{1'b1, 1'b0, 8'h0A, 8'h0B, 8'h0C,
               8'h00, 8'h00, 8'h00, 2'b01, 8};
        run_vec(sv, "pre_rst");
        done_dly = 8;
        b.des2 = 8'hD2;
        b.data2 = 8'h6B;
        b.check2 = 8'hC9;
        byte_q.push_back(8'hD2);
        byte_q.push_back(8'h6B);
        b.req2 = 1'b1;
        ns = 0;
        for (int i = 0; i < 60 && ns < 2; i++) begin
            step();
            if (b.spiStart) ns++;
        end
        chk("rst_second_start", ns, 2);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_clear", {b.spiStart, b.spiByte, b.ack1, b.ack2,
                                b.timeoutErr, b.activePort}, 0);
        b.req2 = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_sb_empty", byte_q.size() + ack_q.size(), 0);
        nack = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (b.ack1 || b.ack2) nack++;
        end
        chk("rst_no_ack", nack, 0);
        sv = '{1'b1, 1'b1, 8'h31, 8'h32, 8'h33,
               8'h41, 8'h42, 8'h43, 2'b01, 1};
        run_vec(sv, "both_after_rst");
        sv = '{1'b1, 1'b1, 8'h51, 8'h52, 8'h53,
               8'h61, 8'h62, 8'h63, 2'b01, 2};
        run_vec(sv, "third_both");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
